// File: rtl/fifo_read_ctrl_if.sv
// fifo_read_ctrl_if
//  Bundles the FIFO read port and the downstream valid/ready handshake of the
//  FIFO read controller into one connection.
//  Signals:
//   FIFO_empty, FIFO_almost_empty, FIFO_almost_full : FIFO status flags
//   FIFO_data_out : FIFO read data, valid one cycle after read_enable
//   read_enable   : FIFO read strobe
//   data_out      : head word of the controller's output buffer
//   valid_out     : data_out holds a word
//   ready_in      : downstream accepts data_out this cycle
//  Modports:
//   master : the controller (drives read_enable and the downstream outputs)
//   slave  : the environment (FIFO plus downstream stage)
interface fifo_read_ctrl_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  FIFO_empty;
    logic                  FIFO_almost_empty;
    logic                  FIFO_almost_full;
    logic [DATA_WIDTH-1:0] FIFO_data_out;
    logic                  read_enable;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  valid_out;
    logic                  ready_in;

    modport master (
        input  FIFO_empty,
        input  FIFO_almost_empty,
        input  FIFO_almost_full,
        input  FIFO_data_out,
        input  ready_in,
        output read_enable,
        output data_out,
        output valid_out
    );

    modport slave (
        output FIFO_empty,
        output FIFO_almost_empty,
        output FIFO_almost_full,
        output FIFO_data_out,
        output ready_in,
        input  read_enable,
        input  data_out,
        input  valid_out
    );
endinterface

// File: rtl/fifo_read_ctrl.sv
// fifo_read_ctrl
//  Consumer-side controller for a synchronous FIFO. Watches the FIFO flags,
//  issues read_enable in bursts (threshold triggered) or continuously while a
//  flush is pending, absorbs the FIFO's one-cycle read latency in a 2-entry
//  output buffer and hands words downstream on a valid/ready handshake.
//  Ports:
//   clk       : clock, all logic on the rising edge
//   Reset     : synchronous active-high reset, wins over every other input
//   Enable    : 0 stops new reads and freezes the FSM; buffer still drains
//   flush     : pulse, requests a drain of the FIFO until it reports empty
//   bus       : FIFO read port + downstream handshake (master modport)
//   busy      : FSM active, or a word buffered or in flight
//   low_water : registered copy of FIFO_almost_empty
//   words_out : number of words accepted downstream, wraps
module fifo_read_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int BURST_LEN  = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 Reset,
    input  logic                 Enable,
    input  logic                 flush,
    fifo_read_ctrl_if.master     bus,
    output logic                 busy,
    output logic                 low_water,
    output logic [CNT_WIDTH-1:0] words_out
);
    localparam int BCW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [BCW-1:0] BURST_LAST = BCW'(BURST_LEN - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t                state;
    logic [BCW-1:0]        burst_cnt;
    logic                  flush_pend;
    logic                  in_flight;
    logic [DATA_WIDTH-1:0] obuf [2];
    logic                  rd_ptr;
    logic                  wr_ptr;
    logic [1:0]            occ;

    logic                  valid;
    logic                  accept;
    logic [2:0]            pending;
    logic                  credit_ok;
    logic                  rd_en;

    // A same-cycle downstream accept frees a slot, so a full buffer being
    // drained can still issue a read and sustain one word per cycle.
    always_comb begin
        valid     = (occ != 2'd0);
        accept    = valid & bus.ready_in;
        pending   = {1'b0, occ} + {2'b00, in_flight} - {2'b00, accept};
        credit_ok = (pending < 3'd2);
        rd_en     = Enable & ~bus.FIFO_empty & credit_ok &
                    ((state == BURST) || (state == FLUSH));
    end

    assign bus.read_enable = rd_en;
    assign bus.valid_out   = valid;
    assign bus.data_out    = obuf[rd_ptr];
    assign busy            = (state != IDLE) || valid || in_flight;

    // Output buffer: the word read last cycle lands in the tail slot, the
    // head slot is presented downstream until accepted.
    always_ff @(posedge clk) begin
        if (Reset) begin
            obuf[0]   <= '0;
            obuf[1]   <= '0;
            rd_ptr    <= 1'b0;
            wr_ptr    <= 1'b0;
            occ       <= 2'd0;
            in_flight <= 1'b0;
            words_out <= '0;
            low_water <= 1'b0;
        end else begin
            low_water <= bus.FIFO_almost_empty;
            in_flight <= rd_en;
            if (in_flight) begin
                obuf[wr_ptr] <= bus.FIFO_data_out;
                wr_ptr       <= ~wr_ptr;
            end
            if (accept) begin
                rd_ptr    <= ~rd_ptr;
                words_out <= words_out + 1'b1;
            end
            case ({in_flight, accept})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: occ <= occ;
            endcase
        end
    end

    // Read-issue FSM. Enable low freezes it entirely; a flush request is
    // remembered in flush_pend until the FIFO has been drained to empty.
    always_ff @(posedge clk) begin
        if (Reset) begin
            state      <= IDLE;
            burst_cnt  <= '0;
            flush_pend <= 1'b0;
        end else begin
            if (flush) begin
                flush_pend <= 1'b1;
            end
            if (Enable) begin
                case (state)
                    IDLE: begin
                        if (!bus.FIFO_empty) begin
                            if (flush_pend) begin
                                state <= FLUSH;
                            end else if (bus.FIFO_almost_full) begin
                                state     <= BURST;
                                burst_cnt <= '0;
                            end
                        end
                    end
                    BURST: begin
                        if (rd_en) begin
                            burst_cnt <= burst_cnt + 1'b1;
                        end
                        if (flush_pend) begin
                            state <= FLUSH;
                        end else if ((rd_en && (burst_cnt == BURST_LAST)) ||
                                     bus.FIFO_empty) begin
                            state <= IDLE;
                        end
                    end
                    FLUSH: begin
                        if (bus.FIFO_empty && !rd_en) begin
                            state <= IDLE;
                            if (!flush) begin
                                flush_pend <= 1'b0;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_fifo_read_ctrl.sv
// tb_fifo_read_ctrl
//  Self-checking bench for fifo_read_ctrl. A behavioural FIFO supplies data
//  with one-cycle read latency; a stream model (words popped from the FIFO in
//  order, words delivered in order) is checked every cycle, and directed
//  scenarios pin read counts, delivered data and counters to literal values.
//  A second instance with a 2-bit counter shares the stimulus to check wrap.
module tb_fifo_read_ctrl;
    localparam int DW = 8;
    localparam int BL = 4;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          Reset;
    logic          Enable;
    logic          flush;
    logic          busy;
    logic          low_water;
    logic [CW-1:0] words_out;
    logic          wbusy;
    logic          wlow_water;
    logic [1:0]    wwords_out;
    logic          af;
    logic          rdy;

    fifo_read_ctrl_if #(.DATA_WIDTH(DW)) bus ();
    fifo_read_ctrl_if #(.DATA_WIDTH(DW)) wbus ();

    // Clock
    always #5 clk = ~clk;

    assign bus.FIFO_almost_full   = af;
    assign bus.ready_in           = rdy;
    assign wbus.FIFO_empty        = bus.FIFO_empty;
    assign wbus.FIFO_almost_empty = bus.FIFO_almost_empty;
    assign wbus.FIFO_almost_full  = af;
    assign wbus.FIFO_data_out     = bus.FIFO_data_out;
    assign wbus.ready_in          = rdy;

    fifo_read_ctrl #(.DATA_WIDTH(DW), .BURST_LEN(BL), .CNT_WIDTH(CW)) dut (
        .clk(clk), .Reset(Reset), .Enable(Enable), .flush(flush), .bus(bus),
        .busy(busy), .low_water(low_water), .words_out(words_out)
    );

    fifo_read_ctrl #(.DATA_WIDTH(DW), .BURST_LEN(BL), .CNT_WIDTH(2)) dut_wrap (
        .clk(clk), .Reset(Reset), .Enable(Enable), .flush(flush), .bus(wbus),
        .busy(wbusy), .low_water(wlow_water), .words_out(wwords_out)
    );

    logic [7:0] pattern [8] = '{8'hFF, 8'hAF, 8'h17, 8'hB8, 8'h6A, 8'h5C, 8'h33, 8'hC4};

    int         checks = 0;
    int         failures = 0;
    bit         mon_on = 1'b0;

    logic [7:0] mem [1024];
    int         wr_idx = 0;
    int         clr_idx = 0;
    int         rd_idx = 0;
    logic [7:0] pend_word = 8'h00;
    bit         pend_valid = 1'b0;

    logic [7:0] exp_q [$];
    int         buf_cnt = 0;
    bit         infl = 1'b0;
    bit         ae_prev = 1'b0;
    int         rd_count = 0;
    int         acc_count = 0;
    int         cyc = 0;
    logic [7:0] got [$];
    int         got_cyc [$];

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Behavioural FIFO: read data and flags change just after the edge that
    // sampled the read strobe.
    always @(posedge clk) begin
        #1;
        if (pend_valid) begin
            bus.FIFO_data_out = pend_word;
        end
        bus.FIFO_empty        = ((wr_idx - ((rd_idx > clr_idx) ? rd_idx : clr_idx)) == 0);
        bus.FIFO_almost_empty = ((wr_idx - ((rd_idx > clr_idx) ? rd_idx : clr_idx)) <= 1);
    end

    // Stream model and per-cycle compare, sampled mid-cycle.
    always @(negedge clk) begin
        logic re;
        logic exp_valid;
        logic acc;
        cyc++;
        if (rd_idx < clr_idx) rd_idx = clr_idx;
        re = bus.read_enable;
        if (mon_on) begin
            exp_valid = (buf_cnt > 0);
            checkOutput("valid_out", bus.valid_out, exp_valid);
            if (exp_valid) checkOutput("data_out", bus.data_out, exp_q[0]);
            checkOutput("words_out", words_out, acc_count[15:0]);
            checkOutput("words_out_wrap", wwords_out, acc_count % 4);
            checkOutput("low_water", low_water, ae_prev);
            checkOutput("read_when_empty", re & bus.FIFO_empty, 0);
            if (re) checkOutput("read_credit", (buf_cnt + infl - ((exp_valid && rdy) ? 1 : 0)) < 2, 1);
            acc = exp_valid && rdy;
            if (acc) begin
                got.push_back(exp_q.pop_front());
                got_cyc.push_back(cyc);
                buf_cnt--;
                acc_count++;
            end
            if (infl) buf_cnt++;
            infl = re;
            ae_prev = bus.FIFO_almost_empty;
        end
        pend_valid = 1'b0;
        if (re) begin
            rd_count++;
            if (wr_idx > rd_idx) begin
                pend_word  = mem[rd_idx];
                pend_valid = 1'b1;
                rd_idx++;
                exp_q.push_back(pend_word);
            end
        end
        if (Reset) begin
            exp_q.delete();
            got.delete();
            got_cyc.delete();
            buf_cnt   = 0;
            infl      = 1'b0;
            ae_prev   = 1'b0;
            rd_count  = 0;
            acc_count = 0;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    // Loads the first n words of the reference pattern into the FIFO.
    task automatic applyStimulus(input int n);
        for (int i = 0; i < n; i++) begin
            mem[wr_idx] = pattern[i];
            wr_idx++;
        end
    endtask

    task automatic doReset();
        Reset   = 1'b1;
        clr_idx = wr_idx;
        af      = 1'b0;
        rdy     = 1'b1;
        flush   = 1'b0;
        Enable  = 1'b1;
        tick(1);
        Reset   = 1'b0;
    endtask

    task automatic waitReads(input int n, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (rd_count >= n) break;
            tick(1);
        end
        checkOutput("wait_reads", rd_count >= n, 1);
    endtask

    task automatic waitIdle(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (!busy) break;
            tick(1);
        end
        checkOutput("wait_idle", busy, 0);
    endtask

    task automatic checkStream(input string name, input int n);
        checkOutput({name, "_count"}, got.size(), n);
        for (int i = 0; i < n; i++) begin
            checkOutput($sformatf("%s_word%0d", name, i),
                        (got.size() > i) ? 32'(got[i]) : 32'hDEAD, 32'(pattern[i]));
        end
    endtask

    // Directed scenarios
    initial begin
        Reset  = 1'b1;
        Enable = 1'b1;
        flush  = 1'b0;
        rdy    = 1'b1;
        af     = 1'b1;

        // Reset held two cycles with almost_full high, then first burst.
        tick(1);
        mon_on = 1'b1;
        applyStimulus(8);
        tick(1);
        checkOutput("reset_read_enable", bus.read_enable, 0);
        checkOutput("reset_valid_out", bus.valid_out, 0);
        checkOutput("reset_words_out", words_out, 0);
        checkOutput("reset_busy", busy, 0);
        Reset = 1'b0;
        @(negedge clk);
        checkOutput("idle_no_read", bus.read_enable, 0);
        @(negedge clk);
        checkOutput("first_read", bus.read_enable, 1);
        tick(1);
        af = 1'b0;
        waitIdle(20);
        checkOutput("burst_reads", rd_count, 4);
        checkStream("burst", 4);
        checkOutput("burst_back_to_back", (got_cyc.size() == 4) ? got_cyc[3] - got_cyc[0] : -1, 3);
        checkOutput("burst_words_out", words_out, 4);

        // Flush of five words, then confirm the flush request was retired.
        doReset();
        applyStimulus(5);
        flush = 1'b1;
        tick(1);
        flush = 1'b0;
        waitReads(5, 30);
        waitIdle(20);
        checkOutput("flush_reads", rd_count, 5);
        checkStream("flush", 5);
        checkOutput("flush_words_out", words_out, 5);
        checkOutput("flush_words_wrap", wwords_out, 1);
        applyStimulus(2);
        tick(6);
        checkOutput("flush_pend_cleared", rd_count, 5);
        checkOutput("flush_idle_busy", busy, 0);

        // Backpressure during a burst.
        doReset();
        rdy = 1'b0;
        af  = 1'b1;
        applyStimulus(8);
        waitReads(1, 10);
        af = 1'b0;
        tick(6);
        checkOutput("bp_reads", rd_count, 2);
        checkOutput("bp_valid", bus.valid_out, 1);
        checkOutput("bp_data", bus.data_out, 8'hFF);
        tick(1);
        checkOutput("bp_data_hold", bus.data_out, 8'hFF);
        rdy = 1'b1;
        waitIdle(20);
        checkOutput("bp_total_reads", rd_count, 4);
        checkStream("bp", 4);
        checkOutput("bp_words_out", words_out, 4);

        // Enable dropped after two reads of a burst.
        doReset();
        af = 1'b1;
        applyStimulus(8);
        waitReads(2, 10);
        Enable = 1'b0;
        af     = 1'b0;
        tick(5);
        checkOutput("en_hold_reads", rd_count, 2);
        checkOutput("en_inflight_delivered", got.size(), 2);
        checkOutput("en_hold_busy", busy, 1);
        Enable = 1'b1;
        waitIdle(20);
        checkOutput("en_total_reads", rd_count, 4);
        checkStream("en", 4);
        checkOutput("en_words_out", words_out, 4);

        // Reset with a word in flight: it must be discarded.
        doReset();
        af = 1'b1;
        applyStimulus(8);
        waitReads(1, 10);
        Reset = 1'b1;
        af    = 1'b0;
        tick(1);
        checkOutput("midrst_valid", bus.valid_out, 0);
        checkOutput("midrst_words_out", words_out, 0);
        Reset = 1'b0;
        tick(3);
        checkOutput("midrst_valid_after", bus.valid_out, 0);
        checkOutput("midrst_busy_after", busy, 0);
        checkOutput("midrst_delivered", got.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Overall time bound
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "[TB] time limit");
    end
endmodule
